// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between the PC register and decode.
// Issues one instruction-memory read per PC value (one request outstanding),
// registers the returned instruction with its PC, and drives pc_stall so the
// PC register only advances on the edge that delivers an instruction.
// Handles memory wait, decode back-pressure (one-entry hold buffer) and flush.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   pc, flush           current PC / redirect (target on pc next cycle)
//   imem_req_*          request handshake (valid/ready, addr)
//   imem_rsp_*          single-cycle response pulse and data
//   if_valid/instr/pc   registered instruction for decode
//   dec_ready           decode consumes if_* this cycle
//   pc_stall            combinational hold to the PC register (1 = hold)
//
// Optional build macro IFU_PERF_CNT_EN adds perf_stall_cycles and
// perf_fetch_count outputs (WIDTH wide, wrapping).

module instr_fetch_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   pc,
  input  logic               flush,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [WIDTH-1:0]   if_pc,
  input  logic               dec_ready,
`ifdef IFU_PERF_CNT_EN
  output logic [WIDTH-1:0]   perf_stall_cycles,
  output logic [WIDTH-1:0]   perf_fetch_count,
`endif
  output logic               pc_stall
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   req_pc;
  logic [INSTR_W-1:0] hold_buf;

  logic can_load;
  logic latch_req;
  logic store_hold;
  logic load_rsp;
  logic load_hold;
  logic load;

  // if_* may be overwritten when empty or being consumed this cycle
  assign can_load = !if_valid || dec_ready;
  assign load     = load_rsp || load_hold;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, handshake outputs and datapath enables; flush wins over all
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    latch_req      = 1'b0;
    store_hold     = 1'b0;
    load_rsp       = 1'b0;
    load_hold      = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req_valid = 1'b1;
        imem_addr      = pc;
        if (flush) begin
          // an accepted request still has a response in flight to discard
          state_d = imem_req_ready ? ST_DRAIN : ST_REQ;
        end else if (imem_req_ready) begin
          latch_req = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          if (can_load) begin
            load_rsp = 1'b1;
            state_d  = ST_REQ;
          end else begin
            store_hold = 1'b1;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_REQ;
        end else if (dec_ready) begin
          load_hold = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC advances only on a delivering edge or a redirect; held during reset
  assign pc_stall = RST ? !(flush || load) : 1'b1;

  // Request PC, hold buffer and decode-facing instruction register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_pc   <= '0;
      hold_buf <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      if (latch_req) req_pc <= pc;

      if (flush)           hold_buf <= '0;
      else if (store_hold) hold_buf <= imem_rsp_data;

      if (flush) begin
        if_valid <= 1'b0;
      end else if (load) begin
        if_valid <= 1'b1;
        if_instr <= load_rsp ? imem_rsp_data : hold_buf;
        if_pc    <= req_pc;
      end else if (dec_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Stall-cycle and delivered-instruction counters, wrapping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_stall_cycles <= '0;
      perf_fetch_count  <= '0;
    end else begin
      if (pc_stall) perf_stall_cycles <= perf_stall_cycles + WIDTH'(1);
      if (load)     perf_fetch_count  <= perf_fetch_count + WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC-register model and a
// fixed/variable-latency instruction memory model.

module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        dec_ready = 1'b1;
  logic        pc_stall;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_fetch_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] pc_reset_val = 32'h0;
  logic [31:0] flush_target = 32'h0;
  int          mem_lat = 1;
  logic        mem_flush = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_addr = 32'h0;
  logic [31:0] ovr_data = 32'h0;

  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  instr_fetch_unit #(.WIDTH(32), .INSTR_W(32)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .pc             (pc),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .dec_ready      (dec_ready),
`ifdef IFU_PERF_CNT_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fetch_count  (perf_fetch_count),
`endif
    .pc_stall       (pc_stall)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return 32'hC0DE_0000 | a;
  endfunction

  // PC register: redirect on flush, +4 when not stalled
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           pc <= pc_reset_val;
    else if (flush)     pc <= flush_target;
    else if (!pc_stall) pc <= pc + 32'd4;
  end

  // Memory: response pulse mem_lat cycles after the accepting edge cycle;
  // independent of DUT reset so late responses can arrive after one
  always_ff @(posedge CLK) begin
    if (mem_flush) begin
      pend           <= 1'b0;
      cnt            <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        paddr <= imem_addr;
        if (mem_lat == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= data_of(imem_addr);
          pend           <= 1'b0;
        end else begin
          pend <= 1'b1;
          cnt  <= mem_lat - 1;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= data_of(paddr);
          pend           <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  // Leaves the bench one step into the first post-reset (IDLE) cycle
  task automatic reset_dut(input logic [31:0] pcv, input int lat);
    next_cycle();
    RST = 1'b0; flush = 1'b0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    mem_flush = 1'b1; pc_reset_val = pcv; mem_lat = lat; ovr_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1; mem_flush = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    RST = 1'b0; flush = 1'b1; mem_flush = 1'b1;
    @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL reset_pc_stall got=%0b exp=1", pc_stall); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got=%h exp=0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    flush = 1'b0;
  endtask

  task automatic test_fetch();
    int k;
    reset_dut(32'h0, 1);
    @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle req_valid got=%0b exp=0", imem_req_valid); end
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      @(negedge CLK);
      if (c % 2 == 1) begin
        k = (c - 1) / 2;
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL fetch_req c=%0d got=%0b/%h exp=1/%h", c, imem_req_valid, imem_addr, 32'(4 * k)); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall c=%0d got=%0b exp=1", c, pc_stall); end
        if (c >= 3) begin
          checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) || if_instr !== data_of(32'(4 * (k - 1)))) begin errors++; $display("FAIL fetch_load c=%0d got=%0b/%h/%h exp=1/%h/%h", c, if_valid, if_pc, if_instr, 32'(4 * (k - 1)), data_of(32'(4 * (k - 1)))); end
        end else begin
          checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_if_valid c=%0d got=%0b exp=0", c, if_valid); end
        end
      end else begin
        checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fetch_load_stall c=%0d got=%0b exp=0", c, pc_stall); end
        checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait c=%0d got=%0b/%0b exp=0/0", c, if_valid, imem_req_valid); end
      end
    end
  endtask

  task automatic test_cache_miss();
    reset_dut(32'h10, 7);
    next_cycle(); @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL miss_req got=%0b/%h exp=1/10", imem_req_valid, imem_addr); end
    for (int c = 2; c <= 7; c++) begin
      next_cycle(); @(negedge CLK);
      checks++; if (pc_stall !== 1'b1 || pc !== 32'h10 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL miss_wait c=%0d got stall=%0b pc=%h req=%0b ifv=%0b exp 1/10/0/0", c, pc_stall, pc, imem_req_valid, if_valid); end
    end
    next_cycle(); @(negedge CLK);
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL miss_rsp_stall got=%0b exp=0", pc_stall); end
    next_cycle(); @(negedge CLK);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== data_of(32'h10)) begin errors++; $display("FAIL miss_load got=%0b/%h/%h exp=1/10/%h", if_valid, if_pc, if_instr, data_of(32'h10)); end
`ifdef IFU_PERF_CNT_EN
    checks++; if (perf_stall_cycles !== 32'd8) begin errors++; $display("FAIL perf_stall got=%0d exp=8", perf_stall_cycles); end
    checks++; if (perf_fetch_count !== 32'd1) begin errors++; $display("FAIL perf_fetch got=%0d exp=1", perf_fetch_count); end
`endif
    next_cycle(); @(negedge CLK);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL miss_single got=%0b exp=0", if_valid); end
  endtask

  task automatic test_back_pressure();
    reset_dut(32'h0, 1);
    ovr_en = 1'b1; ovr_addr = 32'h4; ovr_data = 32'hDEADBEEF; dec_ready = 1'b0;
    next_cycle(); next_cycle(); next_cycle(); @(negedge CLK);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin errors++; $display("FAIL bp_first got=%0b/%h/%h exp=1/0/4", if_valid, if_pc, imem_addr); end
    next_cycle(); @(negedge CLK);
    checks++; if (pc_stall !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_wait got=%0b/%h exp=1/0", pc_stall, if_pc); end
    for (int c = 5; c <= 6; c++) begin
      next_cycle();
      if (c == 6) dec_ready = 1'b1;
      @(negedge CLK);
      checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_instr !== data_of(32'h0) || if_pc !== 32'h0) begin errors++; $display("FAIL bp_hold c=%0d got=%0b/%0b/%h/%h exp=0/1/%h/0", c, imem_req_valid, if_valid, if_instr, if_pc, data_of(32'h0)); end
      checks++; if (pc_stall !== (c == 6 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL bp_stall c=%0d got=%0b exp=%0b", c, pc_stall, (c == 6 ? 1'b0 : 1'b1)); end
    end
    next_cycle(); @(negedge CLK);
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'hDEADBEEF || if_pc !== 32'h4) begin errors++; $display("FAIL bp_release got=%0b/%h/%h exp=1/deadbeef/4", if_valid, if_instr, if_pc); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_next_req got=%0b/%h exp=1/8", imem_req_valid, imem_addr); end
    ovr_en = 1'b0;
  endtask

  task automatic test_flush_wait();
    reset_dut(32'h1C, 1);
    dec_ready = 1'b0;
    next_cycle(); next_cycle();
    mem_lat = 3;
    next_cycle(); @(negedge CLK);
    checks++; if (if_valid !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL fw_setup got=%0b/%h exp=1/20", if_valid, imem_addr); end
    next_cycle();
    flush = 1'b1; flush_target = 32'h100;
    @(negedge CLK);
    checks++; if (pc_stall !== 1'b0 || if_valid !== 1'b1) begin errors++; $display("FAIL fw_flush got=%0b/%0b exp=0/1", pc_stall, if_valid); end
    next_cycle();
    flush = 1'b0;
    @(negedge CLK);
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h100 || pc_stall !== 1'b1) begin errors++; $display("FAIL fw_drain got=%0b/%0b/%h/%0b exp=0/0/100/1", if_valid, imem_req_valid, pc, pc_stall); end
    next_cycle(); @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL fw_discard got=%0b/%0b exp=0/1", imem_req_valid, pc_stall); end
    next_cycle(); @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL fw_redirect got=%0b/%h/%0b exp=1/100/0", imem_req_valid, imem_addr, if_valid); end
  endtask

  task automatic test_flush_rsp_and_reset();
    reset_dut(32'h40, 1);
    next_cycle(); next_cycle();
    flush = 1'b1; flush_target = 32'h200;
    @(negedge CLK);
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fr_flush got=%0b exp=0", pc_stall); end
    next_cycle();
    flush = 1'b0; mem_lat = 4;
    @(negedge CLK);
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL fr_to_req got=%0b/%0b/%h exp=0/1/200", if_valid, imem_req_valid, imem_addr); end
    next_cycle(); next_cycle();
    RST = 1'b0; imem_req_ready = 1'b0;
    @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got=%0b/%0b/%0b exp=0/1/0", imem_req_valid, pc_stall, if_valid); end
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_idle got=%0b exp=0", imem_req_valid); end
    next_cycle(); @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40 || pc_stall !== 1'b1) begin errors++; $display("FAIL rst_stray_req got=%0b/%h/%0b exp=1/40/1", imem_req_valid, imem_addr, pc_stall); end
    next_cycle(); @(negedge CLK);
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_stray_ignored got=%0b/%0b exp=0/1", if_valid, imem_req_valid); end
    imem_req_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fetch();
    test_cache_miss();
    test_back_pressure();
    test_flush_wait();
    test_flush_rsp_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
